// File: rtl/cic_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cic_ctrl_pkg
//   Shared types and constants for the CIC rate sequencer.
//   - state_t        : sequencer FSM states (FLUSH, SETTLE, RUN)
//   - RATE_W         : width of a decimation rate
//   - RATE_*         : the decimation rates the CIC supports
//   - is_legal_rate(): 1 when a requested rate is one of the supported rates
// -----------------------------------------------------------------------------
package cic_ctrl_pkg;

  localparam int RATE_W = 8;

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  // Rates the varcic1 comb/integrator chain supports.
  localparam logic [RATE_W-1:0] RATE_2  = 8'd2;
  localparam logic [RATE_W-1:0] RATE_3  = 8'd3;
  localparam logic [RATE_W-1:0] RATE_4  = 8'd4;
  localparam logic [RATE_W-1:0] RATE_5  = 8'd5;
  localparam logic [RATE_W-1:0] RATE_8  = 8'd8;
  localparam logic [RATE_W-1:0] RATE_10 = 8'd10;
  localparam logic [RATE_W-1:0] RATE_20 = 8'd20;
  localparam logic [RATE_W-1:0] RATE_40 = 8'd40;

  function automatic logic is_legal_rate(input logic [RATE_W-1:0] rate);
    logic legal;
    case (rate)
      RATE_2, RATE_3, RATE_4, RATE_5,
      RATE_8, RATE_10, RATE_20, RATE_40: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/cic_strobe_tagger.sv
// -----------------------------------------------------------------------------
// cic_strobe_tagger
//   DEPTH-deep shift register that carries a "this CIC output is good" tag
//   alongside the CIC's output pipeline, so the tag pops out aligned with
//   the CIC's out_data.
//   Ports:
//     clock    in  1  rising-edge clock
//     reset    in  1  synchronous, active-high; empties the pipe
//     clear    in  1  synchronous clear; empties the pipe, including the
//                     tag presented this clock
//     tag_in   in  1  tag for the CIC output strobe seen this clock
//     tag_out  out 1  tag delayed DEPTH clocks
// -----------------------------------------------------------------------------
module cic_strobe_tagger #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tag_in,
  output logic tag_out
);

  logic [DEPTH-1:0] tag_sr;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      tag_sr <= '0;
    end else begin
      tag_sr[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) begin
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  assign tag_out = tag_sr[DEPTH-1];

endmodule

// File: rtl/cic_rate_sequencer.sv
// -----------------------------------------------------------------------------
// cic_rate_sequencer
//   Sequences run-time decimation changes of the variable-rate CIC (varcic1).
//   A legal, different rate request flushes the CIC, gates its input strobe
//   during the flush, then throws away the settling outputs so downstream
//   only sees clean samples at the new rate.
//
//   Handshake: a request transfers on a clock where req_valid and req_ready
//   are both high. req_ready is high only in RUN; the requester holds
//   req_valid and req_rate stable until the transfer. Every transfer
//   completes: an illegal rate gives a one-clock rate_err, the current rate
//   is a no-op, any other legal rate starts a flush.
//
//   Optional feature (macro CIC_RATE_SEQ_STATUS_EN): adds status[31:0] =
//   {last applied rate, saturating reject count, saturating change count}.
//
//   Ports:
//     clock           in   1  system clock
//     reset           in   1  synchronous, active-high
//     req_rate        in   8  requested decimation
//     req_valid       in   1  request present
//     req_ready       out  1  request accepted when req_valid & req_ready
//     rate_err        out  1  one-clock pulse: illegal rate rejected
//     busy            out  1  high in FLUSH or SETTLE
//     in_strobe       in   1  ADC-side sample strobe
//     cic_in_strobe   out  1  gated strobe to the CIC
//     cic_flush       out  1  clears CIC accumulators and sample counter
//     cic_decimation  out  8  registered rate to the CIC
//     cic_out_strobe  in   1  CIC output strobe
//     data_valid      out  1  qualified strobe aligned to CIC out_data
//     fsm_state       out  2  current sequencer state (state_t encoding)
//     status          out 32  only with CIC_RATE_SEQ_STATUS_EN
// -----------------------------------------------------------------------------
module cic_rate_sequencer
  import cic_ctrl_pkg::*;
#(
  parameter int unsigned DEFAULT_RATE   = 40,
  parameter int unsigned FLUSH_CYCLES   = 8,
  parameter int unsigned SETTLE_OUTPUTS = 4,
  parameter int unsigned OUT_DELAY      = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [RATE_W-1:0] req_rate,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              rate_err,
  output logic              busy,
  input  logic              in_strobe,
  output logic              cic_in_strobe,
  output logic              cic_flush,
  output logic [RATE_W-1:0] cic_decimation,
  input  logic              cic_out_strobe,
  output logic              data_valid,
  output logic [1:0]        fsm_state
`ifdef CIC_RATE_SEQ_STATUS_EN
  ,
  output logic [31:0]       status
`endif
);

  localparam logic [7:0]        FLUSH_LAST  = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_OUTPUTS - 1);
  localparam logic [RATE_W-1:0] RESET_RATE  = RATE_W'(DEFAULT_RATE);

  state_t      state;
  logic [7:0]  flush_cnt;
  logic [7:0]  settle_cnt;

  logic accept;
  logic req_legal;
  logic req_same;
  logic flush_start;
  logic err_req;
  logic settle_done;
  logic tag_in;

  // Request decode. accept can only be high in RUN because req_ready is.
  assign accept      = req_valid && req_ready;
  assign req_legal   = is_legal_rate(req_rate);
  assign req_same    = (req_rate == cic_decimation);
  assign flush_start = accept && req_legal && !req_same;
  assign err_req     = accept && !req_legal;

  // Last settle strobe: RUN starts on the following clock.
  assign settle_done = (state == SETTLE) && cic_out_strobe &&
                       (settle_cnt == SETTLE_LAST);

  // Zero-latency pass-through outside FLUSH. The strobe on the clock that
  // accepts a rate change is also dropped: it belongs to the old rate and
  // the CIC is about to be cleared anyway.
  assign cic_in_strobe = in_strobe && (state != FLUSH) && !flush_start;

  // Only RUN strobes are worth tagging. A strobe that coincides with a
  // rate-change acceptance loses: the clear below wipes it as well.
  assign tag_in = cic_out_strobe && (state == RUN) && !flush_start;

  assign fsm_state = state;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= FLUSH;
      flush_cnt      <= '0;
      settle_cnt     <= '0;
      cic_decimation <= RESET_RATE;
      cic_flush      <= 1'b1;
      busy           <= 1'b1;
      req_ready      <= 1'b0;
      rate_err       <= 1'b0;
    end else begin
      rate_err <= err_req;
      case (state)
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state      <= SETTLE;
            flush_cnt  <= '0;
            settle_cnt <= '0;
            cic_flush  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + 8'd1;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            state      <= RUN;
            settle_cnt <= '0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
          end else if (cic_out_strobe) begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        RUN: begin
          if (flush_start) begin
            state          <= FLUSH;
            flush_cnt      <= '0;
            cic_decimation <= req_rate;
            cic_flush      <= 1'b1;
            busy           <= 1'b1;
            req_ready      <= 1'b0;
          end
        end
        default: begin
          state          <= FLUSH;
          flush_cnt      <= '0;
          settle_cnt     <= '0;
          cic_flush      <= 1'b1;
          busy           <= 1'b1;
          req_ready      <= 1'b0;
        end
      endcase
    end
  end

  // Output qualification pipe, matched to the CIC's out_data latency.
  cic_strobe_tagger #(
    .DEPTH (OUT_DELAY)
  ) u_tagger (
    .clock   (clock),
    .reset   (reset),
    .clear   (flush_start),
    .tag_in  (tag_in),
    .tag_out (data_valid)
  );

`ifdef CIC_RATE_SEQ_STATUS_EN
  // A change counts as completed once its settle phase finishes; the flag
  // keeps the post-reset settle from being counted as a change.
  logic [15:0] change_cnt;
  logic [7:0]  reject_cnt;
  logic        change_pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      change_cnt     <= '0;
      reject_cnt     <= '0;
      change_pending <= 1'b0;
    end else begin
      if (flush_start) begin
        change_pending <= 1'b1;
      end else if (settle_done && change_pending) begin
        change_pending <= 1'b0;
        if (change_cnt != 16'hFFFF) begin
          change_cnt <= change_cnt + 16'd1;
        end
      end
      if (err_req && (reject_cnt != 8'hFF)) begin
        reject_cnt <= reject_cnt + 8'd1;
      end
    end
  end

  // cic_decimation is exactly the last applied rate.
  assign status = {cic_decimation, reject_cnt, change_cnt};
`endif

endmodule

// File: tb/tb_cic_rate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cic_rate_sequencer
//   Drives cic_rate_sequencer with directed scenarios followed by random
//   requests, strobes and resets. A reference model tracks the sequencer as
//   "clocks of flush left", "settle strobes left" and the current rate, and
//   keeps the cycle numbers at which data_valid must fire in exp_q.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cic_rate_sequencer;
  import cic_ctrl_pkg::*;

  localparam int unsigned DEFAULT_RATE   = 40;
  localparam int unsigned FLUSH_CYCLES   = 8;
  localparam int unsigned SETTLE_OUTPUTS = 4;
  localparam int unsigned OUT_DELAY      = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clock;
  logic        reset;
  logic [7:0]  req_rate;
  logic        req_valid;
  logic        req_ready;
  logic        rate_err;
  logic        busy;
  logic        in_strobe;
  logic        cic_in_strobe;
  logic        cic_flush;
  logic [7:0]  cic_decimation;
  logic        cic_out_strobe;
  logic        data_valid;
  logic [1:0]  fsm_state;
`ifdef CIC_RATE_SEQ_STATUS_EN
  logic [31:0] status;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  cic_rate_sequencer #(
    .DEFAULT_RATE   (DEFAULT_RATE),
    .FLUSH_CYCLES   (FLUSH_CYCLES),
    .SETTLE_OUTPUTS (SETTLE_OUTPUTS),
    .OUT_DELAY      (OUT_DELAY)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_rate       (req_rate),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .rate_err       (rate_err),
    .busy           (busy),
    .in_strobe      (in_strobe),
    .cic_in_strobe  (cic_in_strobe),
    .cic_flush      (cic_flush),
    .cic_decimation (cic_decimation),
    .cic_out_strobe (cic_out_strobe),
    .data_valid     (data_valid),
    .fsm_state      (fsm_state)
`ifdef CIC_RATE_SEQ_STATUS_EN
    ,
    .status         (status)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks;
  int          n_pass;
  int unsigned cyc;
  logic [31:0] exp_q[$];     // cycles at which data_valid must be high
  int          m_flush_left;
  int          m_settle_left;
  logic [7:0]  m_rate;
  bit          m_err;
  bit          m_pending;
  int          m_changes;
  int          m_rejects;
  bit          last_accept;

  function automatic bit legal_rate(input logic [7:0] r);
    int rates[8] = '{2, 3, 4, 5, 8, 10, 20, 40};
    bit hit = 1'b0;
    foreach (rates[i]) if (int'(r) == rates[i]) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [7:0] pick_legal();
    int rates[8] = '{2, 3, 4, 5, 8, 10, 20, 40};
    return 8'(rates[$urandom_range(0, 7)]);
  endfunction

  task automatic model_reset();
    m_flush_left  = FLUSH_CYCLES;
    m_settle_left = SETTLE_OUTPUTS;
    m_rate        = 8'(DEFAULT_RATE);
    m_err         = 1'b0;
    m_pending     = 1'b0;
    m_changes     = 0;
    m_rejects     = 0;
    exp_q.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // ---------------- driver: one clock of stimulus + checks ----------------
  // Called just after a falling edge; returns just after the next one.
  task automatic step(input bit rst, input bit ins, input bit outs,
                      input bit rv, input logic [7:0] rr);
    bit running, acc, lg, fs, dv_exp;
    logic [1:0] st_exp;
    reset          = rst;
    in_strobe      = ins;
    cic_out_strobe = outs;
    req_valid      = rv;
    req_rate       = rr;
    #1;
    running = (m_flush_left == 0) && (m_settle_left == 0);
    acc     = rv && running;
    lg      = legal_rate(rr);
    fs      = acc && lg && (rr != m_rate);
    dv_exp  = (exp_q.size() > 0) && (exp_q[0] == cyc);
    st_exp  = (m_flush_left > 0) ? FLUSH : ((m_settle_left > 0) ? SETTLE : RUN);
    check("req_ready",      {31'd0, req_ready},     {31'd0, running});
    check("busy",           {31'd0, busy},          {31'd0, !running});
    check("cic_flush",      {31'd0, cic_flush},     {31'd0, m_flush_left > 0});
    check("cic_decimation", {24'd0, cic_decimation}, {24'd0, m_rate});
    check("rate_err",       {31'd0, rate_err},      {31'd0, m_err});
    check("cic_in_strobe",  {31'd0, cic_in_strobe},
          {31'd0, ins && (m_flush_left == 0) && !fs});
    check("data_valid",     {31'd0, data_valid},    {31'd0, dv_exp});
    check("fsm_state",      {30'd0, fsm_state},     {30'd0, st_exp});
`ifdef CIC_RATE_SEQ_STATUS_EN
    check("status", status, {m_rate, 8'(m_rejects), 16'(m_changes)});
`endif
    if (dv_exp) void'(exp_q.pop_front());
    last_accept = acc;
    @(posedge clock);
    if (rst) begin
      model_reset();
    end else begin
      m_err = acc && !lg;
      if (m_err && m_rejects < 255) m_rejects++;
      if (fs) begin
        m_rate        = rr;
        m_flush_left  = FLUSH_CYCLES;
        m_settle_left = SETTLE_OUTPUTS;
        m_pending     = 1'b1;
        exp_q.delete();
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (m_settle_left > 0) begin
        if (outs) begin
          m_settle_left--;
          if (m_settle_left == 0 && m_pending) begin
            if (m_changes < 65535) m_changes++;
            m_pending = 1'b0;
          end
        end
      end else if (outs) begin
        exp_q.push_back(cyc + OUT_DELAY);
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom_range(0, 1)), (cyc % 3) == 0, 1'b0, 8'd0);
  endtask

  task automatic wait_run(input int limit);
    int n = 0;
    while (!(m_flush_left == 0 && m_settle_left == 0) && n < limit) begin
      step(1'b0, 1'($urandom_range(0, 1)), n[0], 1'b0, 8'd0);
      n++;
    end
    check("wait_run_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // Hold a request until the handshake completes (bounded).
  task automatic drive_req(input logic [7:0] rate, input int limit);
    int n = 0;
    do begin
      step(1'b0, 1'($urandom_range(0, 1)), n[0], 1'b1, rate);
      n++;
    end while (!last_accept && n < limit);
    check("req_accepted", {31'd0, last_accept}, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit         drv_valid;
    logic [7:0] drv_rate;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    reset = 1'b1; req_valid = 1'b0; req_rate = 8'd0;
    in_strobe = 1'b0; cic_out_strobe = 1'b0;
    model_reset();
    @(negedge clock);

    // Reset for 3 clocks, release, flush at 40, settle, tagged outputs.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    wait_run(100);
    idle(12);

    // Illegal rate: rejected, rate stays 40, cadence unchanged.
    drive_req(8'd7, 50);
    idle(10);

    // Same rate: no-op.
    drive_req(m_rate, 50);
    idle(6);

    // Change to 10, with a second request held through FLUSH/SETTLE.
    drive_req(8'd10, 50);
    drive_req(8'd20, 200);
    wait_run(200);
    idle(8);

    // Request and output strobe on the same RUN clock.
    idle(3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
    check("same_clk_accept", {31'd0, last_accept}, 32'd1);
    idle(6);
    wait_run(200);
    idle(4);

    // Reset in the middle of SETTLE.
    drive_req(8'd8, 50);
    idle(FLUSH_CYCLES);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    wait_run(100);

    // Reset mid-FLUSH and mid-RUN arrive via the random phase.
    drv_valid = 1'b0;
    drv_rate  = 8'd0;
    for (int i = 0; i < 4000; i++) begin
      if (!drv_valid && $urandom_range(0, 24) == 0) begin
        drv_valid = 1'b1;
        case ($urandom_range(0, 3))
          0:       drv_rate = m_rate;
          1:       drv_rate = 8'($urandom_range(0, 255));
          default: drv_rate = pick_legal();
        endcase
      end
      step($urandom_range(0, 599) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0, drv_valid, drv_rate);
      if (last_accept) drv_valid = 1'b0;
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
